etherneco_tx_framer: RTL and testbench

//  Parametrised Etherneco transmit framer; successor of the fixed 8-bit framer. Wraps an 8-bit
//  AXI4-Stream-like payload as preamble, SFD, length field, payload, optional padding and optional FCS.

---
 rtl/etherneco_tx_framer.sv | 236 +++++++++++++++++++++++
 tb/tb_etherneco_tx_framer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etherneco_tx_framer.sv
// Etherneco TX framer: preamble, SFD, LE length, payload, pad and optional FCS (ETHERNECO_TX_FCS_EN).
// One output register stage; first beat one cycle after tx_start; everything stalls while m_valid && !m_ready.
module etherneco_tx_framer #(
   parameter int         PREAMBLE_LEN = 7,
   parameter int         LENGTH_BYTES = 2,
   parameter int         LENGTH_WIDTH = 16,
   parameter int         MIN_LENGTH   = 0,
   parameter logic [7:0] PAD_DATA     = 8'h00
) (
   input  logic                    reset,
   input  logic                    clk,
   input  logic                    tx_start,
   input  logic [LENGTH_WIDTH-1:0] tx_length,
   input  logic                    tx_cancel,
   output logic                    busy,
   output logic                    tx_done,
   output logic                    tx_error,
   input  logic                    s_last,
   input  logic [7:0]              s_data,
   input  logic                    s_valid,
   output logic                    s_ready,
   output logic                    m_first,
   output logic                    m_last,
   output logic [7:0]              m_data,
   output logic                    m_valid,
   input  logic                    m_ready
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_SFD, S_LENGTH, S_PAYLOAD, S_PAD, S_FCS, S_ERROR
   } state_t;

   localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
   localparam logic [3:0] LEN_LAST = 4'(LENGTH_BYTES - 1);
   localparam logic [LENGTH_WIDTH-1:0] MIN_M1 =
      (MIN_LENGTH > 0) ? LENGTH_WIDTH'(MIN_LENGTH - 1) : '0;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [LENGTH_WIDTH-1:0] len_q, len_d;
   logic [LENGTH_WIDTH-1:0] rem_q, rem_d;
   logic [LENGTH_WIDTH-1:0] dcnt_q, dcnt_d;
   logic                    m_valid_q, m_valid_d;
   logic                    m_first_q, m_first_d;
   logic                    m_last_q, m_last_d;
   logic [7:0]              m_data_q, m_data_d;
   logic                    err_q, err_d;
   logic                    cke;
   logic                    data_end;
   logic [8*LENGTH_BYTES-1:0] len_ext;
   logic [7:0]              len_byte;

`ifdef ETHERNECO_TX_FCS_EN
   logic [31:0] crc_q, crc_d;

   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {d, 24'h000000};
      for (int i = 0; i < 8; i++) begin
         r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
      end
      return r;
   endfunction
`endif

   assign cke      = !m_valid_q || m_ready;
   assign s_ready  = cke && (state_q == S_PAYLOAD);
   assign busy     = (state_q != S_IDLE) || m_valid_q;
   assign tx_done  = m_valid_q && m_ready && m_last_q && !err_q;
   assign tx_error = m_valid_q && m_ready && err_q;
   assign m_valid  = m_valid_q;
   assign m_first  = m_first_q;
   assign m_last   = m_last_q;
   assign m_data   = m_data_q;

   always_comb begin
      len_ext = '0;
      len_ext[LENGTH_WIDTH-1:0] = len_q;
      len_byte = 8'h00;
      for (int i = 0; i < LENGTH_BYTES; i++) begin
         if (cnt_q == 4'(i)) len_byte = len_ext[8*i +: 8];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      rem_d     = rem_q;
      dcnt_d    = dcnt_q;
      m_valid_d = m_valid_q;
      m_first_d = m_first_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      err_d     = err_q;
      data_end  = 1'b0;
      if (cke) begin
         m_valid_d = 1'b0;
         m_first_d = 1'b0;
         m_last_d  = 1'b0;
         m_data_d  = 8'h00;
         err_d     = 1'b0;
         // A cancel mid-frame defers to ERROR, which emits the single abort beat next.
         if (tx_cancel && state_q != S_ERROR) begin
            state_d = (state_q == S_IDLE) ? S_IDLE : S_ERROR;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (tx_start && !m_valid_q) begin
                     m_valid_d = 1'b1;
                     m_first_d = 1'b1;
                     m_data_d  = 8'h55;
                     len_d     = tx_length;
                     rem_d     = tx_length;
                     dcnt_d    = (tx_length > MIN_M1) ? tx_length : MIN_M1;
                     cnt_d     = 4'd1;
                     state_d   = (PREAMBLE_LEN == 1) ? S_SFD : S_PREAMBLE;
                  end
               end
               S_PREAMBLE: begin
                  m_valid_d = 1'b1;
                  m_data_d  = 8'h55;
                  cnt_d     = cnt_q + 4'd1;
                  if (cnt_q == PRE_LAST) state_d = S_SFD;
               end
               S_SFD: begin
                  m_valid_d = 1'b1;
                  m_data_d  = 8'hD5;
                  cnt_d     = 4'd0;
                  state_d   = S_LENGTH;
               end
               S_LENGTH: begin
                  m_valid_d = 1'b1;
                  m_data_d  = len_byte;
                  cnt_d     = cnt_q + 4'd1;
                  if (cnt_q == LEN_LAST) state_d = S_PAYLOAD;
               end
               S_PAYLOAD: begin
                  // Source stall or missing s_last at the final counted byte aborts the frame.
                  if (!s_valid || (!s_last && rem_q == '0)) begin
                     state_d = S_ERROR;
                  end else begin
                     m_valid_d = 1'b1;
                     m_data_d  = s_data;
                     rem_d     = rem_q - 1'b1;
                     dcnt_d    = dcnt_q - 1'b1;
                     if (s_last) begin
                        if (dcnt_q == '0) data_end = 1'b1;
                        else              state_d  = S_PAD;
                     end
                  end
               end
               S_PAD: begin
                  m_valid_d = 1'b1;
                  m_data_d  = PAD_DATA;
                  dcnt_d    = dcnt_q - 1'b1;
                  if (dcnt_q == '0) data_end = 1'b1;
               end
`ifdef ETHERNECO_TX_FCS_EN
               S_FCS: begin
                  m_valid_d = 1'b1;
                  m_data_d  = crc_q[{cnt_q[1:0], 3'b000} +: 8];
                  cnt_d     = cnt_q + 4'd1;
                  if (cnt_q == 4'd3) begin
                     m_last_d = 1'b1;
                     state_d  = S_IDLE;
                  end
               end
`endif
               S_ERROR: begin
                  m_valid_d = 1'b1;
                  m_last_d  = 1'b1;
                  err_d     = 1'b1;
                  state_d   = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase
            if (data_end) begin
`ifdef ETHERNECO_TX_FCS_EN
               cnt_d    = 4'd0;
               state_d  = S_FCS;
`else
               m_last_d = 1'b1;
               state_d  = S_IDLE;
`endif
            end
         end
      end
   end

`ifdef ETHERNECO_TX_FCS_EN
   // CRC restarts with the first preamble beat and covers only length, payload and pad beats.
   always_comb begin
      crc_d = crc_q;
      if (cke && m_valid_d) begin
         if (state_q == S_IDLE) begin
            crc_d = 32'hFFFF_FFFF;
         end else if (state_q == S_LENGTH || state_q == S_PAYLOAD || state_q == S_PAD) begin
            crc_d = crc_next(crc_q, m_data_d);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) crc_q <= 32'hFFFF_FFFF;
      else       crc_q <= crc_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         len_q     <= '0;
         rem_q     <= '0;
         dcnt_q    <= '0;
         m_valid_q <= 1'b0;
         m_first_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_data_q  <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         rem_q     <= rem_d;
         dcnt_q    <= dcnt_d;
         m_valid_q <= m_valid_d;
         m_first_q <= m_first_d;
         m_last_q  <= m_last_d;
         m_data_q  <= m_data_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_etherneco_tx_framer.sv
// Directed bench for etherneco_tx_framer: default instance plus a MIN_LENGTH=8 instance for padding.
module tb_etherneco_tx_framer;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          reset, tx_start, p_tx_start, tx_cancel, s_last, s_valid, m_ready;
   logic [LW-1:0] tx_length;
   logic [7:0]    s_data;
   logic          busy, tx_done, tx_error, s_ready, m_first, m_last, m_valid;
   logic [7:0]    m_data;
   logic          p_busy, p_tx_done, p_tx_error, p_s_ready, p_m_first, p_m_last, p_m_valid;
   logic [7:0]    p_m_data;
   logic          sel;
   logic          c_busy, c_tx_done, c_tx_error, c_s_ready, c_m_first, c_m_last, c_m_valid;
   logic [7:0]    c_m_data;

   always #5 clk = ~clk;

   etherneco_tx_framer dut (
      .reset(reset), .clk(clk), .tx_start(tx_start), .tx_length(tx_length), .tx_cancel(tx_cancel),
      .busy(busy), .tx_done(tx_done), .tx_error(tx_error), .s_last(s_last), .s_data(s_data),
      .s_valid(s_valid), .s_ready(s_ready), .m_first(m_first), .m_last(m_last), .m_data(m_data),
      .m_valid(m_valid), .m_ready(m_ready));

   etherneco_tx_framer #(.MIN_LENGTH(8)) dut_pad (
      .reset(reset), .clk(clk), .tx_start(p_tx_start), .tx_length(tx_length), .tx_cancel(tx_cancel),
      .busy(p_busy), .tx_done(p_tx_done), .tx_error(p_tx_error), .s_last(s_last), .s_data(s_data),
      .s_valid(s_valid), .s_ready(p_s_ready), .m_first(p_m_first), .m_last(p_m_last),
      .m_data(p_m_data), .m_valid(p_m_valid), .m_ready(m_ready));

   assign c_busy     = sel ? p_busy     : busy;
   assign c_tx_done  = sel ? p_tx_done  : tx_done;
   assign c_tx_error = sel ? p_tx_error : tx_error;
   assign c_s_ready  = sel ? p_s_ready  : s_ready;
   assign c_m_first  = sel ? p_m_first  : m_first;
   assign c_m_last   = sel ? p_m_last   : m_last;
   assign c_m_valid  = sel ? p_m_valid  : m_valid;
   assign c_m_data   = sel ? p_m_data   : m_data;

   int          n_cmp = 0, n_fail = 0;
   logic [7:0]  src_dat[$];
   logic        src_lst[$];
   logic [7:0]  rx_dat[$];
   logic [1:0]  rx_fl[$];
   logic [7:0]  exp_q[$];
   int          done_cnt, err_cnt, hold_viol;
   logic        last_seen, gap, bp_rand, hold_pend, to;
   logic [10:0] hold_val;
   logic [9:0]  got, want;

   // One cycle: drive at the falling edge, observe the handshakes 1 time unit later.
   task automatic tick();
      m_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = (src_dat.size() > 0) && !gap;
      s_data  = (src_dat.size() > 0) ? src_dat[0] : 8'h00;
      s_last  = (src_dat.size() > 0) ? src_lst[0] : 1'b0;
      #1;
      if (hold_pend && {c_m_valid, c_m_first, c_m_last, c_m_data} !== hold_val) hold_viol++;
      hold_pend = c_m_valid && !m_ready;
      hold_val  = {c_m_valid, c_m_first, c_m_last, c_m_data};
      if (c_m_valid && m_ready) begin
         rx_dat.push_back(c_m_data);
         rx_fl.push_back({c_m_first, c_m_last});
         if (c_m_last) last_seen = 1'b1;
      end
      if (s_valid && c_s_ready) begin
         void'(src_dat.pop_front());
         void'(src_lst.pop_front());
      end
      if (c_tx_done)  done_cnt++;
      if (c_tx_error) err_cnt++;
      @(negedge clk);
   endtask

   task automatic start_frame(input logic [LW-1:0] len);
      rx_dat = {}; rx_fl = {};
      done_cnt = 0; err_cnt = 0; hold_viol = 0; last_seen = 1'b0; hold_pend = 1'b0;
      tx_length = len;
      if (sel) p_tx_start = 1'b1; else tx_start = 1'b1;
      tick();
      tx_start = 1'b0; p_tx_start = 1'b0;
   endtask

   task automatic wait_last(output logic timeout);
      for (int i = 0; i < 400 && !last_seen; i++) tick();
      timeout = !last_seen;
   endtask

   task automatic push_src(input logic [7:0] d, input logic l);
      src_dat.push_back(d); src_lst.push_back(l);
   endtask

   task automatic exp_hdr(input logic [7:0] l0);
      exp_q = {};
      repeat (7) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      exp_q.push_back(l0);
      exp_q.push_back(8'h00);
   endtask

   // Appends the FCS over everything after the SFD, bit-serial CRC-32, LSB byte first.
   task automatic exp_fcs();
`ifdef ETHERNECO_TX_FCS_EN
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < exp_q.size(); i++) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[31] ^ exp_q[i][b];
            c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
         end
      end
      for (int k = 0; k < 4; k++) exp_q.push_back(c[8*k +: 8]);
`endif
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if ({c_m_valid, c_m_first, c_m_last, c_m_data} !== 11'h000) begin
         n_fail++; $display("FAIL reset_out: got %h want 000", {c_m_valid, c_m_first, c_m_last, c_m_data});
      end
      n_cmp++;
      if ({c_busy, c_tx_done, c_tx_error, c_s_ready} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_status: got %b want 0000", {c_busy, c_tx_done, c_tx_error, c_s_ready});
      end
      reset = 1'b0;
      tick();
      push_src(8'h11, 1'b0); push_src(8'h22, 1'b1);
      start_frame(16'd1);
      repeat (4) tick();
      n_cmp++;
      if (c_busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b want 1", c_busy); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if ({c_m_valid, c_busy} !== 2'b00) begin
         n_fail++; $display("FAIL midframe_reset: valid,busy got %b want 00", {c_m_valid, c_busy});
      end
      src_dat = {}; src_lst = {};
      tick();
   endtask

   task automatic test_basic();
      push_src(8'h11, 1'b0); push_src(8'h22, 1'b0); push_src(8'h33, 1'b0); push_src(8'h44, 1'b1);
      start_frame(16'd3);
      n_cmp++;
      if ({c_m_valid, c_m_first, c_m_data} !== 10'h355) begin
         n_fail++; $display("FAIL t1_latency: got %h want 355", {c_m_valid, c_m_first, c_m_data});
      end
      wait_last(to);
      exp_hdr(8'h03);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      exp_fcs();
      n_cmp++;
      if (to || rx_dat.size() != exp_q.size()) begin
         n_fail++; $display("FAIL t1_beats: got %0d (timeout %b) want %0d", rx_dat.size(), to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got  = (i < rx_dat.size()) ? {rx_fl[i], rx_dat[i]} : 10'bx;
         want = {i == 0, i == exp_q.size() - 1, exp_q[i]};
         n_cmp++;
         if (got !== want) begin n_fail++; $display("FAIL t1_beat%0d: got %h want %h", i, got, want); end
      end
      n_cmp++;
      if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin
         n_fail++; $display("FAIL t1_pulses: done %0d err %0d want 1 0", done_cnt, err_cnt);
      end
      tick();
   endtask

   task automatic test_min_pad();
      sel = 1'b1;
      push_src(8'hAA, 1'b0); push_src(8'hBB, 1'b1);
      start_frame(16'd1);
      wait_last(to);
      exp_hdr(8'h01);
      exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
      repeat (6) exp_q.push_back(8'h00);
      exp_fcs();
      n_cmp++;
      if (to || rx_dat.size() != exp_q.size()) begin
         n_fail++; $display("FAIL t2_beats: got %0d (timeout %b) want %0d", rx_dat.size(), to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got  = (i < rx_dat.size()) ? {rx_fl[i], rx_dat[i]} : 10'bx;
         want = {i == 0, i == exp_q.size() - 1, exp_q[i]};
         n_cmp++;
         if (got !== want) begin n_fail++; $display("FAIL t2_beat%0d: got %h want %h", i, got, want); end
      end
      n_cmp++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL t2_done: got %0d want 1", done_cnt); end
      tick();
      sel = 1'b0;
   endtask

   task automatic test_short_pad();
      push_src(8'hA1, 1'b0); push_src(8'hB2, 1'b0); push_src(8'hC3, 1'b1);
      start_frame(16'd5);
      wait_last(to);
      exp_hdr(8'h05);
      exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
      repeat (3) exp_q.push_back(8'h00);
      exp_fcs();
      n_cmp++;
      if (to || rx_dat.size() != exp_q.size()) begin
         n_fail++; $display("FAIL t3_beats: got %0d (timeout %b) want %0d", rx_dat.size(), to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got  = (i < rx_dat.size()) ? {rx_fl[i], rx_dat[i]} : 10'bx;
         want = {i == 0, i == exp_q.size() - 1, exp_q[i]};
         n_cmp++;
         if (got !== want) begin n_fail++; $display("FAIL t3_beat%0d: got %h want %h", i, got, want); end
      end
      n_cmp++;
      if ({done_cnt, err_cnt} !== {32'd1, 32'd0}) begin
         n_fail++; $display("FAIL t3_pulses: done %0d err %0d want 1 0", done_cnt, err_cnt);
      end
      tick();
   endtask

   task automatic test_underflow();
      push_src(8'h11, 1'b0); push_src(8'h22, 1'b0); push_src(8'h33, 1'b0); push_src(8'h44, 1'b1);
      start_frame(16'd3);
      for (int i = 0; i < 100 && src_dat.size() > 2; i++) tick();
      gap = 1'b1;
      tick();
      gap = 1'b0;
      wait_last(to);
      src_dat = {}; src_lst = {};
      exp_hdr(8'h03);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h00);
      n_cmp++;
      if (to || rx_dat.size() != exp_q.size()) begin
         n_fail++; $display("FAIL t4_beats: got %0d (timeout %b) want %0d", rx_dat.size(), to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got  = (i < rx_dat.size()) ? {rx_fl[i], rx_dat[i]} : 10'bx;
         want = {i == 0, i == exp_q.size() - 1, exp_q[i]};
         n_cmp++;
         if (got !== want) begin n_fail++; $display("FAIL t4_beat%0d: got %h want %h", i, got, want); end
      end
      n_cmp++;
      if ({done_cnt, err_cnt} !== {32'd0, 32'd1}) begin
         n_fail++; $display("FAIL t4_pulses: done %0d err %0d want 0 1", done_cnt, err_cnt);
      end
      tick();
      n_cmp++;
      if ({c_busy, c_m_valid} !== 2'b00) begin
         n_fail++; $display("FAIL t4_idle: busy,valid got %b want 00", {c_busy, c_m_valid});
      end
   endtask

   task automatic test_overflow();
      push_src(8'h11, 1'b0); push_src(8'h22, 1'b0); push_src(8'h33, 1'b1);
      start_frame(16'd1);
      wait_last(to);
      src_dat = {}; src_lst = {};
      exp_hdr(8'h01);
      exp_q.push_back(8'h11); exp_q.push_back(8'h00);
      n_cmp++;
      if (to || rx_dat.size() != exp_q.size()) begin
         n_fail++; $display("FAIL ovf_beats: got %0d (timeout %b) want %0d", rx_dat.size(), to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got  = (i < rx_dat.size()) ? {rx_fl[i], rx_dat[i]} : 10'bx;
         want = {i == 0, i == exp_q.size() - 1, exp_q[i]};
         n_cmp++;
         if (got !== want) begin n_fail++; $display("FAIL ovf_beat%0d: got %h want %h", i, got, want); end
      end
      n_cmp++;
      if (err_cnt !== 1) begin n_fail++; $display("FAIL ovf_error: got %0d want 1", err_cnt); end
      tick();
   endtask

   task automatic test_cancel();
      push_src(8'h11, 1'b0); push_src(8'h22, 1'b0); push_src(8'h33, 1'b0); push_src(8'h44, 1'b1);
      start_frame(16'd3);
      for (int i = 0; i < 100 && rx_dat.size() < 8; i++) tick();
      tx_cancel = 1'b1; tx_start = 1'b1;
      tick();
      tx_cancel = 1'b0; tx_start = 1'b0;
      wait_last(to);
      repeat (4) tick();
      src_dat = {}; src_lst = {};
      exp_hdr(8'h03);
      void'(exp_q.pop_back());
      exp_q.push_back(8'h00);
      n_cmp++;
      if (to || rx_dat.size() != exp_q.size()) begin
         n_fail++; $display("FAIL t5_beats: got %0d (timeout %b) want %0d", rx_dat.size(), to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got  = (i < rx_dat.size()) ? {rx_fl[i], rx_dat[i]} : 10'bx;
         want = {i == 0, i == exp_q.size() - 1, exp_q[i]};
         n_cmp++;
         if (got !== want) begin n_fail++; $display("FAIL t5_beat%0d: got %h want %h", i, got, want); end
      end
      n_cmp++;
      if ({done_cnt, err_cnt, c_busy} !== {32'd0, 32'd1, 1'b0}) begin
         n_fail++; $display("FAIL t5_status: done %0d err %0d busy %b want 0 1 0", done_cnt, err_cnt, c_busy);
      end
      // Cancel and start together while idle: nothing may start.
      rx_dat = {}; rx_fl = {};
      tx_cancel = 1'b1; tx_start = 1'b1;
      tick();
      tx_cancel = 1'b0; tx_start = 1'b0;
      repeat (3) tick();
      n_cmp++;
      if ({c_busy, 32'(rx_dat.size())} !== {1'b0, 32'd0}) begin
         n_fail++; $display("FAIL t5_idle_cancel: busy %b beats %0d want 0 0", c_busy, rx_dat.size());
      end
   endtask

   task automatic test_backpressure();
      bp_rand = 1'b1;
      push_src(8'h11, 1'b0); push_src(8'h22, 1'b0); push_src(8'h33, 1'b0); push_src(8'h44, 1'b1);
      start_frame(16'd3);
      wait_last(to);
      bp_rand = 1'b0;
      exp_hdr(8'h03);
      exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      exp_fcs();
      n_cmp++;
      if (to || rx_dat.size() != exp_q.size()) begin
         n_fail++; $display("FAIL t6_beats: got %0d (timeout %b) want %0d", rx_dat.size(), to, exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got  = (i < rx_dat.size()) ? {rx_fl[i], rx_dat[i]} : 10'bx;
         want = {i == 0, i == exp_q.size() - 1, exp_q[i]};
         n_cmp++;
         if (got !== want) begin n_fail++; $display("FAIL t6_beat%0d: got %h want %h", i, got, want); end
      end
      n_cmp++;
      if (hold_viol !== 0) begin n_fail++; $display("FAIL t6_hold: got %0d changes want 0", hold_viol); end
      n_cmp++;
      if (done_cnt !== 1) begin n_fail++; $display("FAIL t6_done: got %0d want 1", done_cnt); end
      tick();
   endtask

   initial begin
      reset = 1'b1; tx_start = 1'b0; p_tx_start = 1'b0; tx_cancel = 1'b0; tx_length = '0;
      s_last = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b1;
      sel = 1'b0; gap = 1'b0; bp_rand = 1'b0; hold_pend = 1'b0; hold_val = '0;
      done_cnt = 0; err_cnt = 0; hold_viol = 0; last_seen = 1'b0; to = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_min_pad();
      test_short_pad();
      test_underflow();
      test_overflow();
      test_cancel();
      test_backpressure();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
